bp_cfg_io_endpoint: RTL and testbench

I/O command sink that sits directly downstream of the NBF loader and the other I/O masters. It accepts uncached `bp_cce_mem_msg_s` commands addressed to this tile's config device and decodes them into the per-core configuration registers: freeze, NPC, I$ mode and D$ mode. It returns exactly one `io_resp` per accepted command, which is what returns credits to the master's `bsg_flow_counter`. Its outputs drive core bring-up; the freeze output holds the core until the loader's FREEZE_CLR write arrives.

---
 rtl/bp_cfg_io_endpoint_pkg.sv | 73 +++++++
 rtl/bp_cfg_io_endpoint_if.sv | 21 ++
 rtl/bp_cfg_io_endpoint_resp_reg.sv | 49 ++++
 rtl/bp_cfg_io_endpoint.sv | 103 ++++++++++
 tb/tb_bp_cfg_io_endpoint.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_cfg_io_endpoint_pkg.sv
// Shared types and constants for the per-tile config I/O endpoint:
// message layout, local address view, register map and response FSM states.
package bp_cfg_io_endpoint_pkg;

  localparam int paddr_width_p    = 40;
  localparam int vaddr_width_p    = 39;
  localparam int dword_width_p    = 64;
  localparam int cce_id_width_p   = 6;
  localparam int cfg_dev_width_lp = 4;
  localparam int cfg_addr_width_lp = 20;
  localparam int payload_width_lp = 16;
  localparam int rsvd_width_lp    = paddr_width_p - 1 - cce_id_width_p - cfg_dev_width_lp - cfg_addr_width_lp;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011,
    e_cce_mem_pre   = 4'b0100
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'b000,
    e_mem_size_2  = 3'b001,
    e_mem_size_4  = 3'b010,
    e_mem_size_8  = 3'b011,
    e_mem_size_16 = 3'b100,
    e_mem_size_32 = 3'b101,
    e_mem_size_64 = 3'b110
  } bp_mem_size_e;

  typedef struct packed {
    logic [rsvd_width_lp-1:0]     rsvd;
    logic                         nonlocal;
    logic [cce_id_width_p-1:0]    cce;
    logic [cfg_dev_width_lp-1:0]  dev;
    logic [cfg_addr_width_lp-1:0] addr;
  } bp_local_addr_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e        msg_type;
    logic [paddr_width_p-1:0]    addr;
    bp_mem_size_e                size;
    logic [payload_width_lp-1:0] payload;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    bp_cce_mem_msg_header_s   header;
    logic [dword_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  localparam logic [cfg_dev_width_lp-1:0]  cfg_dev_gp                = 4'h2;
  localparam logic [cfg_addr_width_lp-1:0] bp_cfg_reg_freeze_gp      = 20'h00008;
  localparam logic [cfg_addr_width_lp-1:0] bp_cfg_reg_npc_gp         = 20'h00010;
  localparam logic [cfg_addr_width_lp-1:0] bp_cfg_reg_icache_mode_gp = 20'h00018;
  localparam logic [cfg_addr_width_lp-1:0] bp_cfg_reg_dcache_mode_gp = 20'h00020;

  typedef enum logic {
    e_state_ready = 1'b0,
    e_state_resp  = 1'b1
  } bp_cfg_resp_state_e;

  function automatic logic is_write(input bp_cce_mem_cmd_type_e t);
    return (t == e_cce_mem_wr) || (t == e_cce_mem_uc_wr);
  endfunction

  function automatic logic is_read(input bp_cce_mem_cmd_type_e t);
    return (t == e_cce_mem_rd) || (t == e_cce_mem_uc_rd);
  endfunction

endpackage

// File: rtl/bp_cfg_io_endpoint_if.sv
// Command/response handshake bundle between an I/O master and the config endpoint.
interface bp_cfg_io_endpoint_if;
  import bp_cfg_io_endpoint_pkg::*;

  bp_cce_mem_msg_s io_cmd;
  logic            io_cmd_v;
  logic            io_cmd_yumi;
  bp_cce_mem_msg_s io_resp;
  logic            io_resp_v;
  logic            io_resp_ready;

  modport master (
    output io_cmd, io_cmd_v, io_resp_ready,
    input  io_cmd_yumi, io_resp, io_resp_v
  );

  modport slave (
    input  io_cmd, io_cmd_v, io_resp_ready,
    output io_cmd_yumi, io_resp, io_resp_v
  );
endinterface

// File: rtl/bp_cfg_io_endpoint_resp_reg.sv
// Single-entry response register with its READY/RESP control FSM; a new response
// may be loaded on the same edge the held one is handed off.
module bp_cfg_io_resp_reg
  import bp_cfg_io_endpoint_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  bp_cce_mem_msg_s msg_i,
  input  logic            ready_i,
  output logic            accept_ok_o,
  output logic            v_o,
  output bp_cce_mem_msg_s msg_o
);

  bp_cfg_resp_state_e state_q, state_d;
  bp_cce_mem_msg_s    msg_p1;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_state_ready;
    else         state_q <= state_d;
  end

  // p0 -> p1: payload register carries no reset; validity comes from state_q
  always_ff @(posedge clk_i) begin
    if (load_i) msg_p1 <= msg_i;
  end

  always_comb begin
    state_d     = state_q;
    accept_ok_o = 1'b0;
    v_o         = 1'b0;
    case (state_q)
      e_state_ready: begin
        accept_ok_o = 1'b1;
        if (load_i) state_d = e_state_resp;
      end
      e_state_resp: begin
        v_o         = 1'b1;
        accept_ok_o = ready_i;
        if (ready_i && !load_i) state_d = e_state_ready;
      end
      default: state_d = e_state_ready;
    endcase
  end

  assign msg_o = msg_p1;

endmodule

// File: rtl/bp_cfg_io_endpoint.sv
// Config-device I/O sink: decodes uncached commands into freeze/NPC/cache-mode
// registers and returns exactly one response per accepted command.
module bp_cfg_io_endpoint
  import bp_cfg_io_endpoint_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [cce_id_width_p-1:0] cfg_cce_id_i,
  bp_cfg_io_endpoint_if.slave       io,
  output logic                      freeze_o,
  output logic [vaddr_width_p-1:0]  npc_o,
  output logic                      icache_mode_o,
  output logic                      dcache_mode_o,
  output logic                      decode_err_o
);

  bp_cce_mem_msg_s          cmd_p0, resp_p0, resp_p1;
  bp_local_addr_s           laddr_p0;
  logic                     accept_ok, yumi_p0, hit_p0, wr_p0, rd_p0, vld_p1;
  logic                     sel_freeze_p0, sel_npc_p0, sel_icache_p0, sel_dcache_p0, mapped_p0;
  logic [dword_width_p-1:0] rd_data_p0;
  logic                     unused_p0;

  assign cmd_p0   = io.io_cmd;
  assign laddr_p0 = cmd_p0.header.addr;
  assign wr_p0    = is_write(cmd_p0.header.msg_type);
  assign rd_p0    = is_read(cmd_p0.header.msg_type);
  assign hit_p0   = !laddr_p0.nonlocal && (laddr_p0.cce == cfg_cce_id_i) && (laddr_p0.dev == cfg_dev_gp);

  // accept_ok comes from registered state and ready_i only, so yumi has no self-loop
  assign yumi_p0        = io.io_cmd_v && accept_ok && !reset_i;
  assign io.io_cmd_yumi = yumi_p0;

  always_comb begin
    sel_freeze_p0 = 1'b0;
    sel_npc_p0    = 1'b0;
    sel_icache_p0 = 1'b0;
    sel_dcache_p0 = 1'b0;
    rd_data_p0    = '0;
    if (hit_p0) begin
      case (laddr_p0.addr)
        bp_cfg_reg_freeze_gp: begin
          sel_freeze_p0 = 1'b1;
          rd_data_p0    = dword_width_p'(freeze_o);
        end
        bp_cfg_reg_npc_gp: begin
          sel_npc_p0 = 1'b1;
          rd_data_p0 = dword_width_p'(npc_o);
        end
        bp_cfg_reg_icache_mode_gp: begin
          sel_icache_p0 = 1'b1;
          rd_data_p0    = dword_width_p'(icache_mode_o);
        end
        bp_cfg_reg_dcache_mode_gp: begin
          sel_dcache_p0 = 1'b1;
          rd_data_p0    = dword_width_p'(dcache_mode_o);
        end
        default: ;
      endcase
    end
  end

  assign mapped_p0 = sel_freeze_p0 || sel_npc_p0 || sel_icache_p0 || sel_dcache_p0;

  always_comb begin
    resp_p0        = cmd_p0;
    resp_p0.data   = (rd_p0 && mapped_p0) ? rd_data_p0 : '0;
  end

  // p0 -> p1: config registers update on the accept edge
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_o      <= 1'b1;
      npc_o         <= '0;
      icache_mode_o <= 1'b0;
      dcache_mode_o <= 1'b0;
      decode_err_o  <= 1'b0;
    end else if (yumi_p0) begin
      if (wr_p0 && sel_freeze_p0) freeze_o      <= cmd_p0.data[0];
      if (wr_p0 && sel_npc_p0)    npc_o         <= cmd_p0.data[vaddr_width_p-1:0];
      if (wr_p0 && sel_icache_p0) icache_mode_o <= cmd_p0.data[0];
      if (wr_p0 && sel_dcache_p0) dcache_mode_o <= cmd_p0.data[0];
      if (!mapped_p0)             decode_err_o  <= 1'b1;
    end
  end

  bp_cfg_io_resp_reg u_resp_reg (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (yumi_p0),
    .msg_i       (resp_p0),
    .ready_i     (io.io_resp_ready),
    .accept_ok_o (accept_ok),
    .v_o         (vld_p1),
    .msg_o       (resp_p1)
  );

  assign io.io_resp   = resp_p1;
  assign io.io_resp_v = vld_p1;

  assign unused_p0 = ^{cmd_p0.data[dword_width_p-1:vaddr_width_p], laddr_p0.rsvd};

endmodule

// File: tb/tb_bp_cfg_io_endpoint.sv
// Directed bench for bp_cfg_io_endpoint with a queue-based response scoreboard.
module tb_bp_cfg_io_endpoint;
  import bp_cfg_io_endpoint_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i;
  logic [cce_id_width_p-1:0] cfg_cce_id;
  logic freeze, icache_mode, dcache_mode, decode_err;
  logic [vaddr_width_p-1:0] npc;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_cnt = 0;
  bp_cce_mem_msg_s exp_q[$];

  always #5 clk_i = ~clk_i;

  bp_cfg_io_endpoint_if bus ();

  bp_cfg_io_endpoint dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cfg_cce_id_i  (cfg_cce_id),
    .io            (bus),
    .freeze_o      (freeze),
    .npc_o         (npc),
    .icache_mode_o (icache_mode),
    .dcache_mode_o (dcache_mode),
    .decode_err_o  (decode_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic nl,
                                         input logic [5:0] cce, input logic [3:0] dev,
                                         input logic [19:0] a, input bp_mem_size_e sz,
                                         input logic [15:0] pl, input logic [63:0] d);
    bp_local_addr_s  la;
    bp_cce_mem_msg_s m;
    la = '0;
    la.nonlocal = nl;
    la.cce = cce;
    la.dev = dev;
    la.addr = a;
    m.header.msg_type = t;
    m.header.addr = la;
    m.header.size = sz;
    m.header.payload = pl;
    m.data = d;
    return m;
  endfunction

  // Monitor: a handshake seen at the negedge completes on the following posedge
  always @(negedge clk_i) begin
    if (!reset_i && bus.io_resp_v && bus.io_resp_ready) begin
      resp_cnt++;
      if (exp_q.size() == 0) chk("resp_unexpected", 128'(bus.io_resp), 128'h0);
      else chk("resp", 128'(bus.io_resp), 128'(exp_q.pop_front()));
    end
  end

  task automatic send(input bp_cce_mem_msg_s cmd, input logic [63:0] rdata, output int waited);
    bp_cce_mem_msg_s e;
    waited = 0;
    bus.io_cmd   = cmd;
    bus.io_cmd_v = 1'b1;
    @(negedge clk_i);
    while (!bus.io_cmd_yumi && waited < 20) begin
      waited++;
      @(negedge clk_i);
    end
    if (!bus.io_cmd_yumi) begin
      chk("yumi_timeout", 128'(waited), 128'h0);
    end else begin
      e = cmd;
      e.data = rdata;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    bus.io_cmd_v = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int r0;
    bp_cce_mem_msg_s a_cmd, a_exp, b_cmd;

    reset_i = 1'b1;
    cfg_cce_id = '0;
    bus.io_resp_ready = 1'b1;
    bus.io_cmd = mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_freeze_gp, e_mem_size_8, 16'h0, 64'h0);
    bus.io_cmd_v = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("yumi_in_reset", 128'(bus.io_cmd_yumi), 128'h0);
    end
    @(posedge clk_i);
    #1;
    bus.io_cmd_v = 1'b0;
    reset_i = 1'b0;
    chk("rst_freeze", 128'(freeze), 128'h1);
    chk("rst_npc", 128'(npc), 128'h0);
    chk("rst_icache", 128'(icache_mode), 128'h0);
    chk("rst_dcache", 128'(dcache_mode), 128'h0);
    chk("rst_err", 128'(decode_err), 128'h0);
    chk("rst_resp_v", 128'(bus.io_resp_v), 128'h0);

    // Freeze clear
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_freeze_gp, e_mem_size_8, 16'h00a5, 64'h0), 64'h0, w);
    chk("freeze_clr", 128'(freeze), 128'h0);
    chk("freeze_resp_v", 128'(bus.io_resp_v), 128'h1);
    idle(2);

    // NPC write then read, cache modes, width boundaries
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_8, 16'h0001, 64'h0000_0000_8000_0000), 64'h0, w);
    chk("npc_wr", 128'(npc), 128'h80000000);
    send(mk(e_cce_mem_uc_rd, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_4, 16'h0002, 64'hdead), 64'h0000_0000_8000_0000, w);
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_icache_mode_gp, e_mem_size_4, 16'h0003, 64'h1), 64'h0, w);
    chk("icache_set", 128'(icache_mode), 128'h1);
    send(mk(e_cce_mem_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_icache_mode_gp, e_mem_size_8, 16'h0004, 64'hffff_ffff_ffff_fffe), 64'h0, w);
    chk("icache_lastwins", 128'(icache_mode), 128'h0);
    send(mk(e_cce_mem_rd, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_icache_mode_gp, e_mem_size_8, 16'h0005, 64'h0), 64'h0, w);
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_dcache_mode_gp, e_mem_size_4, 16'h0006, 64'h3), 64'h0, w);
    chk("dcache_set", 128'(dcache_mode), 128'h1);
    send(mk(e_cce_mem_rd, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_dcache_mode_gp, e_mem_size_4, 16'h0007, 64'h0), 64'h1, w);
    send(mk(e_cce_mem_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_8, 16'h0008, 64'hffff_ffff_ffff_ffff), 64'h0, w);
    chk("npc_allones", 128'(npc), 128'h7f_ffff_ffff);
    send(mk(e_cce_mem_uc_rd, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_freeze_gp, e_mem_size_8, 16'h0009, 64'h0), 64'h0, w);
    idle(2);

    // Backpressure
    bus.io_resp_ready = 1'b0;
    a_cmd = mk(e_cce_mem_uc_rd, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_8, 16'h0010, 64'h0);
    a_exp = a_cmd;
    a_exp.data = 64'h0000_007f_ffff_ffff;
    send(a_cmd, 64'h0000_007f_ffff_ffff, w);
    chk("bp_first_accept", 128'(w), 128'h0);
    b_cmd = mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_dcache_mode_gp, e_mem_size_8, 16'h0011, 64'h0);
    bus.io_cmd = b_cmd;
    bus.io_cmd_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("bp_no_yumi", 128'(bus.io_cmd_yumi), 128'h0);
      chk("bp_hold_v", 128'(bus.io_resp_v), 128'h1);
      chk("bp_hold_msg", 128'(bus.io_resp), 128'(a_exp));
    end
    @(posedge clk_i);
    #1;
    bus.io_resp_ready = 1'b1;
    send(b_cmd, 64'h0, w);
    chk("bp_release_accept", 128'(w), 128'h0);
    chk("bp_dcache", 128'(dcache_mode), 128'h0);
    idle(3);

    // Streaming
    r0 = resp_cnt;
    for (int i = 0; i < 16; i++) begin
      send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_8, 16'(16'h0100 + i), 64'(64'h1000 + i * 8)), 64'h0, w);
      chk("stream_no_stall", 128'(w), 128'h0);
    end
    idle(3);
    chk("stream_resp_cnt", 128'(resp_cnt - r0), 128'd16);
    chk("stream_npc", 128'(npc), 128'h1078);
    chk("stream_err", 128'(decode_err), 128'h0);

    // Decode misses
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd1, cfg_dev_gp, bp_cfg_reg_freeze_gp, e_mem_size_8, 16'h0200, 64'h1), 64'h0, w);
    chk("miss_err", 128'(decode_err), 128'h1);
    send(mk(e_cce_mem_uc_wr, 1'b1, 6'd0, cfg_dev_gp, bp_cfg_reg_icache_mode_gp, e_mem_size_8, 16'h0201, 64'h1), 64'h0, w);
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, 4'h3, bp_cfg_reg_dcache_mode_gp, e_mem_size_8, 16'h0202, 64'h1), 64'h0, w);
    send(mk(e_cce_mem_uc_rd, 1'b0, 6'd0, cfg_dev_gp, 20'h00040, e_mem_size_8, 16'h0203, 64'h0), 64'h0, w);
    send(mk(e_cce_mem_uc_rd, 1'b0, 6'd1, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_8, 16'h0204, 64'h0), 64'h0, w);
    idle(3);
    chk("miss_freeze", 128'(freeze), 128'h0);
    chk("miss_npc", 128'(npc), 128'h1078);
    chk("miss_icache", 128'(icache_mode), 128'h0);
    chk("miss_dcache", 128'(dcache_mode), 128'h0);
    chk("miss_err_sticky", 128'(decode_err), 128'h1);

    // Reset while a response is held
    bus.io_resp_ready = 1'b0;
    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_npc_gp, e_mem_size_8, 16'h0300, 64'h4444), 64'h0, w);
    chk("pre_rst_npc", 128'(npc), 128'h4444);
    bus.io_cmd_v = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_resp_v", 128'(bus.io_resp_v), 128'h0);
    chk("midrst_freeze", 128'(freeze), 128'h1);
    chk("midrst_npc", 128'(npc), 128'h0);
    chk("midrst_err", 128'(decode_err), 128'h0);
    exp_q.delete();
    reset_i = 1'b0;
    bus.io_resp_ready = 1'b1;
    idle(1);

    send(mk(e_cce_mem_uc_wr, 1'b0, 6'd0, cfg_dev_gp, bp_cfg_reg_freeze_gp, e_mem_size_4, 16'h0400, 64'h0), 64'h0, w);
    chk("post_rst_freeze", 128'(freeze), 128'h0);
    idle(4);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
